// File: rtl/alu_ctrl_stage_if.sv
// rtl/alu_ctrl_stage_if.sv - decode-field input and ALU-control output handshake bundle
interface alu_ctrl_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic       op5;
  logic       funct7b5;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] ALUControl;
  logic       illegal;

  modport master (
    output in_valid, ALUOp, funct3, op5, funct7b5, out_ready,
    input  in_ready, out_valid, ALUControl, illegal
  );

  modport slave (
    input  in_valid, ALUOp, funct3, op5, funct7b5, out_ready,
    output in_ready, out_valid, ALUControl, illegal
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - ALU control decode behind a two-entry skid buffer
// Optional illegal-op counter enabled by ALU_CTRL_STATS_EN.
module alu_ctrl_stage (
  input logic             clk,
  input logic             rst,
  alu_ctrl_stage_if.slave bus
`ifdef ALU_CTRL_STATS_EN
  ,
  output logic [15:0]     illegal_count
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t     state;
  logic       out_valid_q;
  logic       in_ready_q;
  logic [2:0] out_ctrl;
  logic       out_ill;
  logic [2:0] skid_ctrl;
  logic       skid_ill;
  logic [2:0] dec_ctrl;
  logic       dec_ill;
  logic       push;
  logic       pop;

  always_comb begin
    dec_ctrl = 3'b000;
    dec_ill  = 1'b0;
    case (bus.ALUOp)
      2'b00: dec_ctrl = 3'b000;
      2'b01: dec_ctrl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          // sub only for R-type with funct7b5; I-type addi shares funct3=000
          3'b000:  dec_ctrl = (bus.op5 & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b111:  dec_ctrl = 3'b010;
          3'b110:  dec_ctrl = 3'b011;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_ctrl    <= 3'b000;
      out_ill     <= 1'b0;
      skid_ctrl   <= 3'b000;
      skid_ill    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            out_ctrl    <= dec_ctrl;
            out_ill     <= dec_ill;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_ctrl <= dec_ctrl;
            out_ill  <= dec_ill;
          end else if (push) begin
            skid_ctrl  <= dec_ctrl;
            skid_ill   <= dec_ill;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            out_ctrl   <= skid_ctrl;
            out_ill    <= skid_ill;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ALUControl = out_ctrl;
  assign bus.illegal    = out_ill;

`ifdef ALU_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_count <= 16'h0000;
    end else if (pop && out_ill && (illegal_count != 16'hFFFF)) begin
      illegal_count <= illegal_count + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have port `in_valid`: input, 1 bit, upstream decode fields valid.
REQ-004 The block SHALL have port `in_ready`: output, 1 bit, stage can accept fields this cycle.
REQ-005 The block SHALL have port `ALUOp`: input, 2 bits, main-decoder op class (00 mem, 01 branch, 10 R/I-type, 11 reserved).
REQ-006 The block SHALL have port `funct3`: input, 3 bits, instruction funct3.
REQ-007 The block SHALL have input ports `op5` and `funct7b5`, 1 bit each, opcode bit 5 and funct7 bit 5.
REQ-008 The block SHALL have port `out_valid`: output, 1 bit, `ALUControl`/`illegal` valid to the ALU/execute side.
REQ-009 The block SHALL have port `out_ready`: input, 1 bit, downstream consumes the output this cycle.
REQ-010 The block SHALL have port `ALUControl`: output, 3 bits, ALU operation (000 add, 001 sub, 010 and, 011 or).
REQ-011 The block SHALL have port `illegal`: output, 1 bit, the entry held in the output register did not decode to a supported operation.

Function
REQ-012 The block SHALL form a transfer on a port when valid and ready are both high at a rising edge of `clk`.
REQ-013 The block SHALL decode ALUOp=00 to 000 (add).
REQ-014 The block SHALL decode ALUOp=01 to 001 (sub).
REQ-015 For ALUOp=10, the block SHALL decode by funct3:
- funct3=000 -> 001 if op5&funct7b5, else 000
- funct3=111 -> 010
- funct3=110 -> 011
- any other funct3 -> 000 with illegal=1
REQ-016 The block SHALL decode ALUOp=11 to 000 with illegal=1.
REQ-017 The block SHALL contain a two-entry buffer: an output register plus one skid register, each holding {ALUControl, illegal}.
REQ-018 The block SHALL implement an occupancy FSM with states EMPTY, ONE and TWO.
REQ-019 `out_valid` SHALL be 1 in states ONE and TWO, and 0 in EMPTY.
REQ-020 `in_ready` SHALL be 1 in states EMPTY and ONE, and 0 in TWO; it SHALL be driven from the state register only, with no combinational path from `out_ready`.
REQ-021 EMPTY: on a push, the decoded entry SHALL load the output register and the FSM SHALL go to ONE; latency from input transfer to `out_valid` SHALL be 1 cycle.
REQ-022 ONE, push only: the new entry SHALL load the skid register and the FSM SHALL go to TWO.
REQ-023 ONE, pop only: the FSM SHALL go to EMPTY; output register contents are don't-care.
REQ-024 ONE, simultaneous push and pop: the new entry SHALL load the output register and the FSM SHALL stay in ONE, with no bubble.
REQ-025 TWO, pop: the skid register SHALL move to the output register and the FSM SHALL go to ONE; a push cannot occur in TWO.
REQ-026 While `out_valid`=1 and `out_ready`=0, `ALUControl` and `illegal` SHALL hold stable.
REQ-027 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-028 Inputs other than `in_valid` SHALL be ignored when no push occurs.

Reset
REQ-029 While `rst`=1 the block SHALL force, asynchronously:
- FSM to EMPTY
- `out_valid`=0
- `in_ready`=1
- `ALUControl`=000
- `illegal`=0
- skid register to 0
REQ-030 Assertion of `rst` mid-transfer SHALL discard all buffered entries.
REQ-031 The first push SHALL be accepted at the first rising edge after `rst` deasserts.

Configuration
REQ-032 When macro ALU_CTRL_STATS_EN is defined, the block SHALL add output `illegal_count` (16 bits), incremented on each output transfer with illegal=1 and saturating at 0xFFFF.
REQ-033 `illegal_count` SHALL reset to 0 by `rst`.
REQ-034 When ALU_CTRL_STATS_EN is undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 The bench SHALL cover single push from reset: ALUOp=10, funct3=000, op5=1, funct7b5=1, out_ready=1 -> next cycle out_valid=1, ALUControl=001, illegal=0; following cycle out_valid=0.
REQ-036 The bench SHALL cover backpressure: out_ready=0; push add (ALUOp=00), then and (funct3=111) -> in_ready=0 after the 2nd push, output holds 000. Raising out_ready then yields 000, then 010 on consecutive cycles.
REQ-037 The bench SHALL cover streaming: out_ready=1, in_valid=1 for 4 cycles with ops sub, or, add, and -> outputs 001, 011, 000, 010 on consecutive cycles, in_ready constantly 1.
REQ-038 The bench SHALL cover illegal decode: ALUOp=10, funct3=001 -> ALUControl=000, illegal=1. With ALU_CTRL_STATS_EN, illegal_count increments from 0 to 1 on the output transfer.
REQ-039 The bench SHALL cover reset mid-operation: in state TWO, assert rst asynchronously between edges -> out_valid=0, in_ready=1, ALUControl=000 immediately, with no stale output after release.
REQ-040 The bench SHALL cover the ALU-decode boundary: ALUOp=10, funct3=000, op5=0, funct7b5=1 -> ALUControl=000 (I-type addi, not sub).
